// File: rtl/vx_raster_pkg.sv
// Shared types and helpers for the depth-first tile evaluator.
// VX_RASTER_TE_TRIVIAL_ACCEPT_EN enables whole-tile emission of covered tiles.
package vx_raster_pkg;

  localparam int TE_TILE_LOGSIZE  = 5;
  localparam int TE_BLOCK_LOGSIZE = 2;
  localparam int TE_DIM_BITS      = 16;
  localparam int TE_DATA_BITS     = 32;

  localparam int LEVELS      = TE_TILE_LOGSIZE - TE_BLOCK_LOGSIZE;
  localparam int STACK_DEPTH = 3 * LEVELS;
  localparam int LVL_BITS    = $clog2(LEVELS + 1);

  // Word order inside one packed edge {a, b, c}
  localparam int EA = 2;
  localparam int EB = 1;
  localparam int EC = 0;

  typedef logic [TE_DIM_BITS-1:0]  te_dim_t;
  typedef logic [TE_DATA_BITS-1:0] te_word_t;

  typedef struct packed {
    te_dim_t             x;
    te_dim_t             y;
    te_word_t [2:0]      eval;
    logic [LVL_BITS-1:0] level;
  } te_entry_t;

  function automatic te_dim_t child_xy(
    te_dim_t base, logic sel, int h
  );
    return sel ? base + (te_dim_t'(1) << h) : base;
  endfunction

  function automatic te_word_t child_eval(
    te_word_t e, te_word_t a, te_word_t b,
    logic i, logic j, int h
  );
    te_word_t r;
    r = e;
    if (i) r = r + (a << h);
    if (j) r = r + (b << h);
    return r;
  endfunction

  // Most negative a*x+b*y over a 2^ls square
  function automatic te_word_t min_off(
    te_word_t a, te_word_t b, int ls
  );
    te_word_t ma;
    te_word_t mb;
    ma = a[TE_DATA_BITS-1] ? a : '0;
    mb = b[TE_DATA_BITS-1] ? b : '0;
    return (ma << ls) - ma + (mb << ls) - mb;
  endfunction

endpackage

// File: rtl/vx_raster_te_stack_if.sv
// Tile-in / block-out bus of the tile evaluator.
// master drives tiles and ready_out; slave is the evaluator.
interface vx_raster_te_stack_if #(
  parameter int DIM_BITS  = 16,
  parameter int DATA_BITS = 32,
  parameter int PID_BITS  = 16
);
  logic                           valid_in;
  logic [DIM_BITS-1:0]            xloc_in;
  logic [DIM_BITS-1:0]            yloc_in;
  logic [PID_BITS-1:0]            pid_in;
  logic [2:0][2:0][DATA_BITS-1:0] edges_in;
  logic [2:0][DATA_BITS-1:0]      extents_in;
  logic                           ready_in;

  logic                           valid_out;
  logic [DIM_BITS-1:0]            xloc_out;
  logic [DIM_BITS-1:0]            yloc_out;
  logic [PID_BITS-1:0]            pid_out;
  logic [2:0][2:0][DATA_BITS-1:0] edges_out;
  logic [DIM_BITS-1:0]            logsize_out;
  logic                           ready_out;

  modport master (
    output valid_in, xloc_in, yloc_in, pid_in,
    output edges_in, extents_in,
    input  ready_in,
    input  valid_out, xloc_out, yloc_out, pid_out,
    input  edges_out, logsize_out,
    output ready_out
  );

  modport slave (
    input  valid_in, xloc_in, yloc_in, pid_in,
    input  edges_in, extents_in,
    output ready_in,
    output valid_out, xloc_out, yloc_out, pid_out,
    output edges_out, logsize_out,
    input  ready_out
  );
endinterface

// File: rtl/vx_raster_te_lifo.sv
// Register-array LIFO: 3-entry push, 1-entry pop.
// push_data_i[0] lands deepest, push_data_i[2] on top.
module vx_raster_te_lifo
  import vx_raster_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  te_entry_t [2:0] push_data_i,
  input  logic            pop_i,
  output te_entry_t       top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int CW = $clog2(DEPTH + 1);

  te_entry_t     mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i)     cnt_d = cnt_q + CW'(3);
    else if (pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++)
          for (int k = 0; k < 3; k++)
            if (i == int'(cnt_q) + k)
              mem_q[i] <= push_data_i[k];
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(cnt_q) == i + 1) top_o = mem_q[i];
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = int'(cnt_q) > DEPTH - 3;

endmodule

// File: rtl/vx_raster_te_stack.sv
// Depth-first tile evaluator emitting blocks in Morton order.
// VX_RASTER_TE_TRIVIAL_ACCEPT_EN: emit fully covered sub-tiles whole.
module vx_raster_te_stack
  import vx_raster_pkg::*;
#(
  parameter int TILE_LOGSIZE  = TE_TILE_LOGSIZE,
  parameter int BLOCK_LOGSIZE = TE_BLOCK_LOGSIZE,
  parameter int DIM_BITS      = TE_DIM_BITS,
  parameter int DATA_BITS     = TE_DATA_BITS,
  parameter int PID_BITS      = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  vx_raster_te_stack_if.slave bus
);

  localparam int LV = TILE_LOGSIZE - BLOCK_LOGSIZE;

  te_entry_t                t_q, t_d;
  logic                     t_vld_q, t_vld_d;
  te_word_t [2:0][2:0]      edg_q, edg_d;
  te_word_t [2:0]           ext_q, ext_d;
  logic [PID_BITS-1:0]      pid_q, pid_d;

  logic                     o_vld_q, o_vld_d;
  te_dim_t                  o_x_q, o_x_d;
  te_dim_t                  o_y_q, o_y_d;
  logic [PID_BITS-1:0]      o_pid_q, o_pid_d;
  te_word_t [2:0][2:0]      o_edg_q, o_edg_d;
  logic [DIM_BITS-1:0]      o_ls_q, o_ls_d;

  int   ls, h;
  logic pass, triv, leaf;
  logic emit, split;
  logic o_free, stall, adv;
  logic push, pop, accept, rdy_in;
  logic stk_empty, stk_full;

  te_entry_t       kid [4];
  te_entry_t       stk_top;
  te_entry_t [2:0] push_data;

  always_comb begin
    logic [DATA_BITS-1:0] s;
    s    = '0;
    ls   = TILE_LOGSIZE - int'(t_q.level);
    h    = ls - 1;
    pass = 1'b1;
    triv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = t_q.eval[k] + (ext_q[k] >> t_q.level);
      if (s[DATA_BITS-1]) pass = 1'b0;
    end
    leaf = (int'(t_q.level) == LV);
`ifdef VX_RASTER_TE_TRIVIAL_ACCEPT_EN
    triv = ~leaf;
    for (int k = 0; k < 3; k++) begin
      s = t_q.eval[k]
        + min_off(edg_q[k][EA], edg_q[k][EB], ls);
      if (s[DATA_BITS-1]) triv = 1'b0;
    end
`endif
    emit  = pass & (leaf | triv);
    split = pass & ~emit;
  end

  // Child n = 2i+j: i steps x, j steps y
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      kid[n].x = child_xy(t_q.x, n[1], h);
      kid[n].y = child_xy(t_q.y, n[0], h);
      for (int k = 0; k < 3; k++)
        kid[n].eval[k] = child_eval(
          t_q.eval[k], edg_q[k][EA], edg_q[k][EB],
          n[1], n[0], h);
      kid[n].level = t_q.level + 1'b1;
    end
  end

  assign push_data = {kid[1], kid[2], kid[3]};

  assign o_free = ~o_vld_q | bus.ready_out;
  assign stall  = emit & ~o_free;
  assign adv    = t_vld_q & ~stall;
  assign push   = adv & split;
  assign pop    = adv & ~split & ~stk_empty;
  assign rdy_in = ~t_vld_q & stk_empty;
  assign accept = bus.valid_in & rdy_in;

  always_comb begin
    t_d     = t_q;
    t_vld_d = t_vld_q;
    edg_d   = edg_q;
    ext_d   = ext_q;
    pid_d   = pid_q;
    if (accept) begin
      t_vld_d = 1'b1;
      t_d.x   = bus.xloc_in;
      t_d.y   = bus.yloc_in;
      for (int k = 0; k < 3; k++)
        t_d.eval[k] = bus.edges_in[k][EC];
      t_d.level = '0;
      edg_d     = bus.edges_in;
      ext_d     = bus.extents_in;
      pid_d     = bus.pid_in;
    end else if (adv) begin
      if (split)           t_d = kid[0];
      else if (!stk_empty) t_d = stk_top;
      else                 t_vld_d = 1'b0;
    end
  end

  always_comb begin
    o_vld_d = o_vld_q;
    o_x_d   = o_x_q;
    o_y_d   = o_y_q;
    o_pid_d = o_pid_q;
    o_edg_d = o_edg_q;
    o_ls_d  = o_ls_q;
    if (o_free) begin
      o_vld_d = t_vld_q & emit;
      if (t_vld_q & emit) begin
        o_x_d   = t_q.x;
        o_y_d   = t_q.y;
        o_pid_d = pid_q;
        for (int k = 0; k < 3; k++) begin
          o_edg_d[k][EA] = edg_q[k][EA];
          o_edg_d[k][EB] = edg_q[k][EB];
          o_edg_d[k][EC] = t_q.eval[k];
        end
        o_ls_d = DIM_BITS'(ls);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_vld_q <= 1'b0;
      t_q     <= '0;
      edg_q   <= '0;
      ext_q   <= '0;
      pid_q   <= '0;
      o_vld_q <= 1'b0;
      o_x_q   <= '0;
      o_y_q   <= '0;
      o_pid_q <= '0;
      o_edg_q <= '0;
      o_ls_q  <= '0;
    end else begin
      t_vld_q <= t_vld_d;
      t_q     <= t_d;
      edg_q   <= edg_d;
      ext_q   <= ext_d;
      pid_q   <= pid_d;
      o_vld_q <= o_vld_d;
      o_x_q   <= o_x_d;
      o_y_q   <= o_y_d;
      o_pid_q <= o_pid_d;
      o_edg_q <= o_edg_d;
      o_ls_q  <= o_ls_d;
    end
  end

  vx_raster_te_lifo #(
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .top_o       (stk_top),
    .empty_o     (stk_empty),
    .full_o      (stk_full)
  );

  runtime_assert_ovf: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(push & stk_full));

  assign bus.ready_in    = rdy_in;
  assign bus.valid_out   = o_vld_q;
  assign bus.xloc_out    = o_x_q;
  assign bus.yloc_out    = o_y_q;
  assign bus.pid_out     = o_pid_q;
  assign bus.edges_out   = o_edg_q;
  assign bus.logsize_out = o_ls_q;

endmodule

// File: tb/tb_vx_raster_te_stack.sv
// Directed + random bench for vx_raster_te_stack against a
// Morton-walk reference model of the tile traversal.
module tb_vx_raster_te_stack;

  localparam int TLS = 5;
  localparam int BLS = 2;
  localparam int LV  = TLS - BLS;
`ifdef VX_RASTER_TE_TRIVIAL_ACCEPT_EN
  localparam bit TRIV = 1'b1;
`else
  localparam bit TRIV = 1'b0;
`endif

  typedef logic [383:0] cv_t;

  typedef struct {
    logic [15:0]  x;
    logic [15:0]  y;
    logic [15:0]  pid;
    logic [15:0]  ls;
    logic [287:0] edges;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vx_raster_te_stack_if #(
    .DIM_BITS(16), .DATA_BITS(32), .PID_BITS(16)
  ) bus ();

  vx_raster_te_stack #(
    .TILE_LOGSIZE(TLS), .BLOCK_LOGSIZE(BLS),
    .DIM_BITS(16), .DATA_BITS(32), .PID_BITS(16)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          pa [3];
  int          pb [3];
  int          pc [3];
  logic [31:0] pext [3];
  logic [15:0] px0, py0, ppid;
  exp_t        q [$];

  task automatic chk(input string tag, input cv_t obs, input cv_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cv_t outs();
    return cv_t'({bus.xloc_out, bus.yloc_out, bus.pid_out,
                  bus.logsize_out, bus.edges_out});
  endfunction

  function automatic logic [31:0] ev(int k, int dx, int dy);
    return 32'(pa[k] * dx + pb[k] * dy + pc[k]);
  endfunction

  function automatic bit hit(int dx, int dy, int lvl);
    logic [31:0] s;
    for (int k = 0; k < 3; k++) begin
      s = ev(k, dx, dy) + (pext[k] >> lvl);
      if (s[31]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Linear edge: minimum over the square sits at a corner
  function automatic bit covered(int dx, int dy, int ls);
    int m;
    logic [31:0] v;
    m = (1 << ls) - 1;
    for (int k = 0; k < 3; k++)
      for (int cx = 0; cx < 2; cx++)
        for (int cy = 0; cy < 2; cy++) begin
          v = ev(k, dx + cx * m, dy + cy * m);
          if (v[31]) return 1'b0;
        end
    return 1'b1;
  endfunction

  // Walk every block in Morton order down its ancestor chain
  task automatic build_model();
    exp_t e;
    logic [2:0][2:0][31:0] ed;
    q.delete();
    for (int m = 0; m < (1 << (2 * LV)); m++) begin
      int dx = 0;
      int dy = 0;
      bit done = 1'b0;
      for (int lvl = 0; lvl <= LV && !done; lvl++) begin
        int ls = TLS - lvl;
        if (!hit(dx, dy, lvl)) begin
          done = 1'b1;
        end else if (lvl == LV || (TRIV && covered(dx, dy, ls))) begin
          done = 1'b1;
          if (m % (1 << (2 * (LV - lvl))) == 0) begin
            for (int k = 0; k < 3; k++) begin
              ed[k][2] = 32'(pa[k]);
              ed[k][1] = 32'(pb[k]);
              ed[k][0] = ev(k, dx, dy);
            end
            e.x = 16'(int'(px0) + dx);
            e.y = 16'(int'(py0) + dy);
            e.pid = ppid;
            e.ls = 16'(ls);
            e.edges = ed;
            q.push_back(e);
          end
        end else begin
          int n = (m >> (2 * (LV - 1 - lvl))) & 3;
          dx += (n >> 1) << (ls - 1);
          dy += (n & 1) << (ls - 1);
        end
      end
    end
  endtask

  task automatic set_uniform(input int c);
    for (int k = 0; k < 3; k++) begin
      pa[k] = 0;
      pb[k] = 0;
      pc[k] = c;
      pext[k] = 32'd0;
    end
    px0 = 16'd0;
    py0 = 16'd0;
  endtask

  task automatic run_prim(input string nm, input bit rnd, input int abort_after,
                          output int nf, output int nr, output int got);
    exp_t e;
    cv_t  sv;
    bit   hold;
    bit   abort;
    int   n;
    int   total;
    nf = -1;
    nr = -1;
    got = 0;
    hold = 1'b0;
    abort = 1'b0;
    n = 0;
    sv = '0;
    build_model();
    total = q.size();
    chk({nm, "_ready_idle"}, cv_t'(bus.ready_in), cv_t'(1'b1));
    bus.xloc_in = px0;
    bus.yloc_in = py0;
    bus.pid_in = ppid;
    for (int k = 0; k < 3; k++) begin
      bus.edges_in[k][2] = 32'(pa[k]);
      bus.edges_in[k][1] = 32'(pb[k]);
      bus.edges_in[k][0] = 32'(pc[k]);
      bus.extents_in[k] = pext[k];
    end
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    chk({nm, "_ready_busy"}, cv_t'(bus.ready_in), cv_t'(1'b0));
    while (n < 3000) begin
      if (bus.valid_out && nf < 0) nf = n;
      if (bus.ready_in && nr < 0) nr = n;
      if (bus.ready_in && !bus.valid_out) break;
      if (hold) begin
        chk({nm, "_hold_valid"}, cv_t'(bus.valid_out), cv_t'(1'b1));
        chk({nm, "_hold_data"}, outs(), sv);
      end
      bus.ready_out = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (bus.valid_out) begin
        if (bus.ready_out) begin
          hold = 1'b0;
          if (q.size() > 0) begin
            e = q.pop_front();
            chk({nm, "_out"}, outs(),
                cv_t'({e.x, e.y, e.pid, e.ls, e.edges}));
          end
          got++;
          if (abort_after > 0 && got == abort_after) abort = 1'b1;
        end else begin
          hold = 1'b1;
          sv = outs();
        end
      end
      @(posedge clk);
      #1;
      n++;
      if (abort) break;
    end
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk({nm, "_rst_valid"}, cv_t'(bus.valid_out), cv_t'(1'b0));
      chk({nm, "_rst_ready"}, cv_t'(bus.ready_in), cv_t'(1'b1));
      chk({nm, "_rst_data"}, outs(), cv_t'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        chk({nm, "_quiet"}, cv_t'({bus.valid_out, bus.ready_in}),
            cv_t'(2'b01));
      end
      bus.ready_out = 1'b1;
    end else begin
      chk({nm, "_in_budget"}, cv_t'(n < 3000), cv_t'(1'b1));
      chk({nm, "_count"}, cv_t'(got), cv_t'(total));
      chk({nm, "_leftover"}, cv_t'(q.size()), cv_t'(0));
    end
  endtask

  initial begin
    int nf, nr, got;
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    bus.xloc_in = '0;
    bus.yloc_in = '0;
    bus.pid_in = '0;
    bus.edges_in = '0;
    bus.extents_in = '0;
    ppid = 16'h00a1;
    #2;
    chk("reset_valid_out", cv_t'(bus.valid_out), cv_t'(1'b0));
    chk("reset_ready_in", cv_t'(bus.ready_in), cv_t'(1'b1));
    chk("reset_data", outs(), cv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_uniform(1);
    run_prim("full", 1'b0, 0, nf, nr, got);
    chk("full_first_latency", cv_t'(nf), cv_t'(TRIV ? 1 : LV + 1));
    chk("full_ready_latency", cv_t'(nr), cv_t'(TRIV ? 1 : 85));
    chk("full_blocks", cv_t'(got), cv_t'(TRIV ? 1 : 64));

    set_uniform(-1);
    ppid = 16'h0bad;
    run_prim("reject", 1'b0, 0, nf, nr, got);
    chk("reject_ready_latency", cv_t'(nr), cv_t'(1));
    chk("reject_blocks", cv_t'(got), cv_t'(0));

    set_uniform(1);
    pa[0] = -1;
    pc[0] = 15;
    ppid = 16'h1234;
    run_prim("half", 1'b0, 0, nf, nr, got);
    chk("half_blocks", cv_t'(got), cv_t'(TRIV ? 2 : 32));

    set_uniform(1);
    ppid = 16'h0042;
    run_prim("full_stall", 1'b1, 0, nf, nr, got);
    chk("full_stall_blocks", cv_t'(got), cv_t'(TRIV ? 1 : 64));

    run_prim("abort", 1'b1, 10, nf, nr, got);

    ppid = 16'h0077;
    run_prim("after_rst", 1'b0, 0, nf, nr, got);
    chk("after_rst_blocks", cv_t'(got), cv_t'(TRIV ? 1 : 64));

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) begin
        pa[k] = int'($urandom_range(12, 0)) - 6;
        pb[k] = int'($urandom_range(12, 0)) - 6;
        pc[k] = int'($urandom_range(120, 0)) - 40;
        pext[k] = 32'($urandom_range(60, 0));
      end
      px0 = 16'($urandom);
      py0 = 16'($urandom);
      ppid = 16'($urandom);
      run_prim("rand", 1'b1, 0, nf, nr, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
